// File: rtl/instr_reader.sv
// Instruction register read-out stage: walks a window of entries, streams each word over valid/ready.
// Define INSTR_READER_CHECK_EN to build the result recompute/compare logic (out_mismatch, err_count).
package instr_reader_pkg;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned OPC_W     = 4;
   localparam int unsigned OPERAND_W = 32;
   localparam int unsigned RESULT_W  = 64;
   localparam int unsigned CNT_W     = 6;

   typedef logic [ADDR_W-1:0]           address_t;
   typedef logic [OPC_W-1:0]            opcode_t;
   typedef logic signed [OPERAND_W-1:0] operand_t;
   typedef logic signed [RESULT_W-1:0]  result_t;

   localparam opcode_t OPC_ZERO  = OPC_W'(0);
   localparam opcode_t OPC_PASSA = OPC_W'(1);
   localparam opcode_t OPC_PASSB = OPC_W'(2);
   localparam opcode_t OPC_ADD   = OPC_W'(3);
   localparam opcode_t OPC_SUB   = OPC_W'(4);
   localparam opcode_t OPC_MULT  = OPC_W'(5);
   localparam opcode_t OPC_DIV   = OPC_W'(6);
   localparam opcode_t OPC_MOD   = OPC_W'(7);

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
      result_t  result;
   } instruction_t;
endpackage

module instr_reader
   import instr_reader_pkg::*;
#(
   parameter int unsigned DEPTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  address_t         first_ptr,
   input  logic [CNT_W-1:0] count,
   output address_t         read_pointer,
   input  instruction_t     instruction_word,
   output logic             out_valid,
   input  logic             out_ready,
   output instruction_t     out_instr,
   output address_t         out_index,
   output logic             out_mismatch,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT} state_t;

   localparam address_t LAST_PTR = ADDR_W'(DEPTH - 1);

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic             start_go_c;
   logic             fetch_c;
   logic             accept_c;

   assign start_go_c = (state == S_IDLE) && start && (count != '0);
   assign fetch_c    = (state == S_FETCH);
   assign accept_c   = (state == S_PRESENT) && out_ready;

   // Window sequencer: FETCH captures the addressed entry, PRESENT holds it until accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         remaining    <= '0;
         read_pointer <= '0;
         out_valid    <= 1'b0;
         out_instr    <= '0;
         out_index    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (count != '0) begin
                     read_pointer <= first_ptr;
                     remaining    <= count;
                     busy         <= 1'b1;
                     state        <= S_FETCH;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               out_instr <= instruction_word;
               out_index <= read_pointer;
               out_valid <= 1'b1;
               state     <= S_PRESENT;
            end
            S_PRESENT: begin
               if (out_ready) begin
                  out_valid    <= 1'b0;
                  remaining    <= remaining - CNT_W'(1);
                  read_pointer <= (read_pointer == LAST_PTR) ? '0 : read_pointer + ADDR_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef INSTR_READER_CHECK_EN
   // Recomputes the result in 64-bit signed arithmetic; divide-by-zero entries are never flagged.
   function automatic logic calc_mismatch(input instruction_t w);
      result_t a;
      result_t b;
      result_t expect_r;
      logic    skip;
      logic    bad_opc;
      a        = result_t'(w.op_a);
      b        = result_t'(w.op_b);
      expect_r = '0;
      skip     = 1'b0;
      bad_opc  = 1'b0;
      case (w.opc)
         OPC_ZERO:  expect_r = '0;
         OPC_PASSA: expect_r = a;
         OPC_PASSB: expect_r = b;
         OPC_ADD:   expect_r = a + b;
         OPC_SUB:   expect_r = a - b;
         OPC_MULT:  expect_r = a * b;
         OPC_DIV: begin
            if (b == '0) skip = 1'b1;
            else         expect_r = a / b;
         end
         OPC_MOD: begin
            if (b == '0) skip = 1'b1;
            else         expect_r = a % b;
         end
         default:   bad_opc = 1'b1;
      endcase
      return bad_opc || (!skip && (expect_r != w.result));
   endfunction

   logic             mismatch_q;
   logic [CNT_W-1:0] err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mismatch_q <= 1'b0;
         err_q      <= '0;
      end else begin
         if (fetch_c) mismatch_q <= calc_mismatch(instruction_word);
         if (start_go_c) begin
            err_q <= '0;
         end else if (accept_c && mismatch_q && (err_q != '1)) begin
            err_q <= err_q + CNT_W'(1);
         end
      end
   end

   assign out_mismatch = mismatch_q;
   assign err_count    = err_q;
`else
   assign out_mismatch = 1'b0;
   assign err_count    = '0;
`endif

endmodule

// File: tb/tb_instr_reader.sv
// Scoreboard bench for instr_reader: directed windows, expected words queued at launch, checked on handshake.
module tb_instr_reader;
   import instr_reader_pkg::*;

   localparam int unsigned CW = 136;
`ifdef INSTR_READER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      address_t     idx;
      instruction_t instr;
      logic         mm;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         out_ready = 1'b0;
   address_t     first_ptr = '0;
   logic [5:0]   count = '0;
   address_t     read_pointer;
   address_t     out_index;
   instruction_t instruction_word;
   instruction_t out_instr;
   logic         out_valid;
   logic         out_mismatch;
   logic         busy;
   logic         done;
   logic [5:0]   err_count;

   instruction_t mem [32];
   exp_t         sb [$];
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

   assign instruction_word = mem[read_pointer];

   instr_reader dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .first_ptr        (first_ptr),
      .count            (count),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instr        (out_instr),
      .out_index        (out_index),
      .out_mismatch     (out_mismatch),
      .busy             (busy),
      .done             (done),
      .err_count        (err_count)
   );

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic instruction_t mk(input opcode_t o, input int a, input int b, input longint r);
      instruction_t w;
      w.opc    = o;
      w.op_a   = a;
      w.op_b   = b;
      w.result = r;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input address_t i, input logic mm);
      exp_t e;
      e.idx   = i;
      e.instr = mem[i];
      e.mm    = mm & CHK;
      sb.push_back(e);
   endtask

   // Pulses start for one edge, then checks the state right after the accepting edge.
   task automatic launch(input address_t p, input logic [5:0] c);
      first_ptr = p;
      count     = c;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("launch_busy", CW'(busy), CW'(1));
      chk("launch_ptr", CW'(read_pointer), CW'(p));
      chk("launch_valid", CW'(out_valid), CW'(0));
   endtask

   task automatic wait_done(input string nm, input int bound, input logic [5:0] exp_err);
      int n = 0;
      while (!done && n < bound) begin
         tick();
         n++;
      end
      chk({nm, "_done"}, CW'(done), CW'(1));
      if (done) begin
         chk({nm, "_busy"}, CW'(busy), CW'(0));
         chk({nm, "_err"}, CW'(err_count), CW'(exp_err));
         tick();
         chk({nm, "_done_pulse"}, CW'(done), CW'(0));
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: got index %0d want no word", out_index);
            end else begin
               e = sb.pop_front();
               chk("sb_index", CW'(out_index), CW'(e.idx));
               chk("sb_instr", CW'(out_instr), CW'(e.instr));
               chk("sb_mismatch", CW'(out_mismatch), CW'(e.mm));
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      instruction_t held;
      for (int i = 0; i < 32; i++) mem[i] = mk(OPC_ZERO, 0, 0, 0);

      // Reset values
      tick();
      tick();
      chk("rst_ptr", CW'(read_pointer), CW'(0));
      chk("rst_valid", CW'(out_valid), CW'(0));
      chk("rst_instr", CW'(out_instr), CW'(0));
      chk("rst_index", CW'(out_index), CW'(0));
      chk("rst_mm", CW'(out_mismatch), CW'(0));
      chk("rst_busy", CW'(busy), CW'(0));
      chk("rst_done", CW'(done), CW'(0));
      chk("rst_err", CW'(err_count), CW'(0));
      reset_n = 1'b1;
      tick();
      fork
         monitor();
      join_none

      // Basic window, ready tied high
      mem[0] = mk(OPC_ADD, 5, 3, 8);
      mem[1] = mk(OPC_SUB, 5, 3, 2);
      mem[2] = mk(OPC_MULT, -4, 3, -12);
      push(0, 1'b0);
      push(1, 1'b0);
      push(2, 1'b0);
      out_ready = 1'b1;
      launch(0, 6'd3);
      tick();
      chk("latency_valid", CW'(out_valid), CW'(1));
      wait_done("basic", 20, 6'd0);

      // Backpressure: hold 5 cycles, entry rewritten while presented
      mem[5] = mk(OPC_PASSA, 11, -3, 11);
      mem[6] = mk(OPC_PASSB, 4, 22, 22);
      held   = mem[5];
      push(5, 1'b0);
      push(6, 1'b0);
      out_ready = 1'b0;
      launch(5, 6'd2);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", CW'(out_valid), CW'(1));
         chk("bp_index", CW'(out_index), CW'(5));
         chk("bp_instr", CW'(out_instr), CW'(held));
         chk("bp_ptr", CW'(read_pointer), CW'(5));
         if (i == 0) mem[5] = mk(OPC_ADD, 0, 0, 1);
         tick();
      end
      out_ready = 1'b1;
      wait_done("bp", 20, 6'd0);

      // Wrap 30,31,0,1 with one bad stored result
      mem[30] = mk(OPC_ZERO, 1, 2, 0);
      mem[31] = mk(OPC_DIV, -9, 2, -4);
      mem[0]  = mk(OPC_MOD, -9, 2, -1);
      mem[1]  = mk(OPC_ADD, 7, 1, 9);
      push(30, 1'b0);
      push(31, 1'b0);
      push(0, 1'b0);
      push(1, 1'b1);
      launch(30, 6'd4);
      wait_done("wrap", 30, CHK ? 6'd1 : 6'd0);

      // Divide by zero, illegal opcode, wide multiply, wrong SUB; start mid-window ignored
      mem[10] = mk(OPC_DIV, 9, 0, 123);
      mem[11] = mk(OPC_W'(9), 1, 2, 3);
      mem[12] = mk(OPC_MULT, 100000, -100000, -64'sd10000000000);
      mem[13] = mk(OPC_SUB, 10, 3, 6);
      push(10, 1'b0);
      push(11, 1'b1);
      push(12, 1'b0);
      push(13, 1'b1);
      launch(10, 6'd4);
      tick();
      tick();
      first_ptr = 20;
      count     = 6'd1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("ign_busy", CW'(busy), CW'(1));
      chk("ign_ptr", CW'(read_pointer), CW'(11));
      wait_done("calc", 30, CHK ? 6'd2 : 6'd0);

      // Zero-length window
      first_ptr = 9;
      count     = 6'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_done", CW'(done), CW'(1));
      chk("zero_busy", CW'(busy), CW'(0));
      chk("zero_valid", CW'(out_valid), CW'(0));
      tick();
      chk("zero_done_pulse", CW'(done), CW'(0));
      chk("zero_busy2", CW'(busy), CW'(0));
      chk("zero_valid2", CW'(out_valid), CW'(0));

      // Reset while presenting
      mem[3] = mk(OPC_PASSA, 1, 2, 1);
      mem[4] = mk(OPC_PASSB, 1, 2, 2);
      out_ready = 1'b0;
      launch(3, 6'd2);
      tick();
      chk("pre_rst_valid", CW'(out_valid), CW'(1));
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", CW'(out_valid), CW'(0));
      chk("mid_rst_busy", CW'(busy), CW'(0));
      chk("mid_rst_ptr", CW'(read_pointer), CW'(0));
      chk("mid_rst_index", CW'(out_index), CW'(0));
      chk("mid_rst_instr", CW'(out_instr), CW'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid_rst_done", CW'(done), CW'(0));
      end
      reset_n = 1'b1;
      tick();
      chk("post_rst_done", CW'(done), CW'(0));
      mem[7] = mk(OPC_ADD, -1, -1, -2);
      push(7, 1'b0);
      out_ready = 1'b1;
      launch(7, 6'd1);
      wait_done("post_rst", 20, 6'd0);

      tick();
      chk("sb_drain", CW'(sb.size()), CW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
